elevator_call_ctrl: RTL

ELEVATOR_CALL_CTRL -- requirements
Module: elevator_call_ctrl

---
 rtl/elevator_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/elevator_call_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call controller: floor encoding,
// call FSM states and parameter defaults.
package elevator_pkg;

  localparam int NUM_FLOORS          = 4;
  localparam int DWELL_CYCLES_DEF    = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    FLOOR_A = 2'd0,
    FLOOR_B = 2'd1,
    FLOOR_C = 2'd2,
    FLOOR_D = 2'd3
  } floor_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_CLOSE = 2'd2
  } call_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One-bit button conditioner: 2-flop synchronizer followed by a stable-run
// filter. Only built when ELEVATOR_CALL_DEBOUNCE_EN is defined.
`ifdef ELEVATOR_CALL_DEBOUNCE_EN
module btn_debounce
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_stable
);

  localparam logic [3:0] RUN_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic       sync1_reg;
  logic       sync2_reg;
  logic       stable_reg;
  logic [3:0] run_reg;

  // run_reg counts consecutive synced samples that disagree with stable_reg
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      run_reg    <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg == stable_reg) begin
        run_reg <= '0;
      end else if (run_reg == RUN_LAST) begin
        stable_reg <= sync2_reg;
        run_reg    <= '0;
      end else begin
        run_reg <= run_reg + 4'd1;
      end
    end
  end

  assign btn_stable = stable_reg;

endmodule
`endif

// File: rtl/elevator_call_ctrl.sv
// Elevator call latch and door dwell controller.
// Optional button debounce enabled by defining ELEVATOR_CALL_DEBOUNCE_EN.
module elevator_call_ctrl
  import elevator_pkg::*;
#(
  parameter int DWELL_CYCLES    = DWELL_CYCLES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [1:0] floor,
  output logic       ra,
  output logic       rb,
  output logic       rc,
  output logic       rd,
  output logic       door_open,
  output logic       busy
);

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES - 1);

  if (DWELL_CYCLES < 2 || DWELL_CYCLES > 255 ||
      DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_param_check
    $error("elevator_call_ctrl: parameter out of legal range");
  end

  logic [NUM_FLOORS-1:0] btn_cond;
  logic [NUM_FLOORS-1:0] btn_prev_reg;
  logic [NUM_FLOORS-1:0] set_vec;
  logic [NUM_FLOORS-1:0] clr_vec;
  logic [NUM_FLOORS-1:0] pending_reg;
  logic [NUM_FLOORS-1:0] pending_next;
  call_state_t           state_reg;
  call_state_t           state_next;
  logic [7:0]            dwell_reg;
  logic [7:0]            dwell_next;
  floor_t                open_floor_reg;
  floor_t                open_floor_next;
  logic                  busy_reg;
  logic                  door_open_reg;

`ifdef ELEVATOR_CALL_DEBOUNCE_EN
  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_debounce
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .btn_raw   (btn[gi]),
      .btn_stable(btn_cond[gi])
    );
  end
`else
  logic [NUM_FLOORS-1:0] btn_sample_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sample_reg <= '0;
    end else begin
      btn_sample_reg <= btn;
    end
  end

  assign btn_cond = btn_sample_reg;
`endif

  assign set_vec      = btn_cond & ~btn_prev_reg;
  // a call arriving in the same cycle as its clear keeps the floor pending
  assign pending_next = (pending_reg & ~clr_vec) | set_vec;

  always_comb begin
    state_next      = state_reg;
    dwell_next      = dwell_reg;
    open_floor_next = open_floor_reg;
    clr_vec         = '0;
    unique case (state_reg)
      ST_IDLE: begin
        if (pending_reg[floor]) begin
          state_next      = ST_OPEN;
          dwell_next      = DWELL_LOAD;
          open_floor_next = floor_t'(floor);
        end
      end
      ST_OPEN: begin
        if (floor_t'(floor) != open_floor_reg) begin
          state_next = ST_CLOSE;
        end else if (dwell_reg == 8'd0) begin
          clr_vec[open_floor_reg] = 1'b1;
          state_next              = ST_CLOSE;
        end else if (set_vec[floor]) begin
          dwell_next = DWELL_LOAD;
        end else begin
          dwell_next = dwell_reg - 8'd1;
        end
      end
      ST_CLOSE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // busy and door_open are registered from next-state values so they line
  // up with pending_reg and state_reg in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      dwell_reg      <= '0;
      open_floor_reg <= FLOOR_A;
      pending_reg    <= '0;
      btn_prev_reg   <= '0;
      busy_reg       <= 1'b0;
      door_open_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      dwell_reg      <= dwell_next;
      open_floor_reg <= open_floor_next;
      pending_reg    <= pending_next;
      btn_prev_reg   <= btn_cond;
      busy_reg       <= |pending_next;
      door_open_reg  <= (state_next == ST_OPEN);
    end
  end

  assign ra        = pending_reg[0];
  assign rb        = pending_reg[1];
  assign rc        = pending_reg[2];
  assign rd        = pending_reg[3];
  assign busy      = busy_reg;
  assign door_open = door_open_reg;

endmodule
